// File: rtl/mio_bus_arbiter.sv
// Memory/IO bus controller: round-robin arbitration between CPU and DMA read port,
// region decode (RAM / seg7 / LED), per-region wait states and ready handshakes.
module mio_bus_arbiter #(
   parameter int unsigned RAM_WAIT = 2,
   parameter int unsigned IO_WAIT  = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ready,
   input  logic        dma_req,
   input  logic [31:0] dma_addr,
   output logic [31:0] dma_rdata,
   output logic        dma_ready,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic        ram_we,
   output logic        seg7_we,
   output logic        led_we,
   input  logic [31:0] ram_rdata,
   input  logic [31:0] io_rdata
);

   localparam logic [3:0] RAM_W = 4'(RAM_WAIT);
   localparam logic [3:0] IO_W  = 4'(IO_WAIT);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        we;
   logic        owner_dma;
   logic        last_dma;
   logic        grant_dma;
   logic [31:0] grant_addr;
   logic        sel_seg7;
   logic        sel_led;
   logic        sel_ram;
   logic        strobe_cycle;
   logic [31:0] rd_sel;

   function automatic logic [3:0] region_wait(input logic [31:0] addr);
      if (addr[31:28] == 4'hF || addr[31:28] == 4'hE) return IO_W;
      return RAM_W;
   endfunction

   // On a tie the master not served last wins; a lone requester always wins.
   always_comb begin
      grant_dma = dma_req;
      if (cpu_req && dma_req) grant_dma = ~last_dma;
   end

   assign grant_addr = grant_dma ? dma_addr : cpu_addr;

   assign sel_seg7     = (bus_addr[31:28] == 4'hF);
   assign sel_led      = (bus_addr[31:28] == 4'hE);
   assign sel_ram      = ~(sel_seg7 | sel_led);
   assign strobe_cycle = (state == ACCESS) && (cnt == 4'd0);

   // Strobes derive only from registered state, so reset kills them immediately.
   assign ram_we  = strobe_cycle & we & sel_ram;
   assign seg7_we = strobe_cycle & we & sel_seg7;
   assign led_we  = strobe_cycle & we & sel_led;
   assign rd_sel  = sel_ram ? ram_rdata : io_rdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         we        <= 1'b0;
         owner_dma <= 1'b0;
         last_dma  <= 1'b1;
         bus_addr  <= 32'd0;
         bus_wdata <= 32'd0;
         cpu_rdata <= 32'd0;
         dma_rdata <= 32'd0;
         cpu_ready <= 1'b0;
         dma_ready <= 1'b0;
      end else begin
         cpu_ready <= 1'b0;
         dma_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req || dma_req) begin
                  owner_dma <= grant_dma;
                  bus_addr  <= grant_addr;
                  cnt       <= region_wait(grant_addr);
                  we        <= ~grant_dma & cpu_we;
                  if (!grant_dma) bus_wdata <= cpu_wdata;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  if (owner_dma) begin
                     dma_rdata <= rd_sel;
                     dma_ready <= 1'b1;
                  end else begin
                     cpu_rdata <= rd_sel;
                     cpu_ready <= 1'b1;
                  end
                  state <= DONE;
               end
            end
            DONE: begin
               last_dma <= owner_dma;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mio_bus_arbiter.md
Name: mio_bus_arbiter

Overview:
- Memory/IO bus controller between the multi-cycle CPU and its shared memory-mapped resources.
- Arbitrates between two masters: the CPU (read/write) and a read-only DMA/display fetch port.
- Decodes the owner's address to RAM, seg7 (0xF000_000x) or LED (0xE000_000x).
- Inserts per-region wait states, and generates the CPU's MIO_ready handshake and a matching DMA ready.

Parameters:
RAM_WAIT, 2, extra wait cycles for RAM accesses (0..15)
IO_WAIT, 0, extra wait cycles for seg7/LED accesses (0..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
cpu_req  in  1  CPU bus request (CPU_MIO), held until cpu_ready
cpu_we  in  1  CPU write enable (mem_w)
cpu_addr  in  32  CPU byte address (Addr_out)
cpu_wdata  in  32  CPU write data (Data_out)
cpu_rdata  out  32  read data to CPU (Data_in), valid while cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse to CPU (MIO_ready)
dma_req  in  1  DMA read request, held until dma_ready
dma_addr  in  32  DMA byte address
dma_rdata  out  32  read data to DMA, valid while dma_ready=1
dma_ready  out  1  one-cycle completion pulse to DMA
bus_addr  out  32  latched address to all slaves
bus_wdata  out  32  latched write data to all slaves
ram_we  out  1  RAM write strobe
seg7_we  out  1  seg7 register write strobe
led_we  out  1  LED register write strobe
ram_rdata  in  32  RAM read data (combinational)
io_rdata  in  32  seg7/LED read data (combinational)

Behaviour:
- Decode of the latched address:
  - addr[31:28]==4'hF selects seg7.
  - addr[31:28]==4'hE selects LED.
  - Anything else selects RAM.
  - The wait count is RAM_WAIT for RAM and IO_WAIT otherwise.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any request is present, grant one owner.
  - Latch bus_addr and the wait counter, and latch bus_wdata/we from the owner (DMA we is forced to 0).
  - Go to ACCESS.
- Arbitration in IDLE:
  - With a single requester, grant that requester.
  - With both requesting, grant the master not granted last (round-robin).
  - last_grant resets to DMA, so the CPU wins the first tie.
- ACCESS:
  - While cnt!=0: decrement cnt and hold all outputs.
  - When cnt==0: assert exactly one of ram_we/seg7_we/led_we for that single cycle (only if the latched we=1).
  - In that same cycle, capture the selected read data (ram_rdata or io_rdata) into a rdata register. Go to DONE.
- DONE:
  - Assert the owner's ready for exactly one cycle, with its rdata output driven from the rdata register.
  - Update last_grant. Go to IDLE.
- Latency: a request sampled at edge E0 produces ready high between E(W+1) and E(W+2), where W is the region wait.
  - RAM_WAIT=2 gives ready in the 4th cycle after grant.
  - IO_WAIT=0 gives ready in the 2nd cycle.
- There is at least one IDLE cycle between transactions. Back-to-back contention therefore alternates CPU, DMA, CPU, ...
- The non-owner's ready stays 0 and its rdata holds its last value.
- A request dropped mid-access does not abort the transaction: it completes, strobes fire and ready still pulses.
- A new request is not sampled until the FSM returns to IDLE.
- Address and data inputs may change after grant without effect, because they are latched.
- Reset (async, any state) forces:
  - state=IDLE and all strobes=0.
  - cpu_ready=dma_ready=0.
  - bus_addr, bus_wdata, cpu_rdata and dma_rdata = 0.
  - cnt=0 and last_grant=DMA.
  - An in-flight write issues no strobe if reset occurs before its final ACCESS cycle.
- Unmapped sub-addresses within 0xE/0xF regions still assert the region strobe. The seg7/LED register file decodes addr[2].

Test Plan:
- Reset low for 3 cycles, then high, with no requests: all outputs 0 and FSM stays IDLE.
- CPU write 0xF000_0000 <= 0x1234_5678 (IO_WAIT=0): seg7_we is high for one cycle with bus_wdata=0x1234_5678. cpu_ready pulses 2 cycles after grant, and ram_we/led_we stay 0.
- CPU read 0x0000_0004 with ram_rdata=0x2014_003F (RAM_WAIT=2): cpu_ready pulses exactly 4 cycles after grant with cpu_rdata=0x2014_003F, and no strobe is asserted.
- cpu_req and dma_req held high together for 4 transactions: grants go CPU, DMA, CPU, DMA. The ready pulses never overlap, and dma never causes a write strobe even with cpu_we=1.
- Reset pulled low during ACCESS of a CPU write to 0xE000_0000: led_we never asserts and cpu_ready stays 0. After release, the FSM is in IDLE and the CPU wins the next tie.
- cpu_req deasserted one cycle after grant: the transaction completes, cpu_ready pulses once, and the next request is not accepted before the FSM returns to IDLE.
